// File: rtl/sspwm_pkg.sv
// rtl/sspwm_pkg.sv - shared widths, mode encoding and elaboration-time helpers for the SSPWM sine path
package sspwm_pkg;

  localparam int DEF_PHASE_W = 8;
  localparam int DEF_ACC_W   = 16;
  localparam int DEF_OUT_W   = 12;
  localparam int DEF_NUM_CH  = 3;
  localparam int DEF_PEAK    = 3710;
  localparam int DEF_MI_W    = 8;

  typedef enum logic {
    MODE_HALF = 1'b0,
    MODE_RECT = 1'b1
  } mode_e;

  localparam longint Q30_ONE = 64'sd1073741824;
  localparam longint PI_Q30  = 64'sd3373259426;

  function automatic longint chan_offset(input int acc_w, input int num_ch);
    return (longint'(1) << acc_w) / longint'(num_ch);
  endfunction

  // Fixed-point (Q30) Taylor series so the table builds without real arithmetic.
  function automatic int sine_rom_val(input int i, input int phase_w, input int peak);
    longint x;
    longint term;
    longint acc;
    x    = (PI_Q30 * longint'(i)) / longint'((1 << (phase_w - 1)) - 1);
    term = x;
    acc  = x;
    for (int n = 1; n <= 7; n++) begin
      term = -((((term * x) / Q30_ONE) * x) / Q30_ONE) / longint'((2 * n) * (2 * n + 1));
      acc  = acc + term;
    end
    return int'((acc * longint'(peak) + Q30_ONE / 2) / Q30_ONE);
  endfunction

endpackage

// File: rtl/sine_quarter_rom.sv
// rtl/sine_quarter_rom.sv - quarter-wave sine table with registered read and zero override
module sine_quarter_rom
  import sspwm_pkg::*;
#(
  parameter int PHASE_W = DEF_PHASE_W,
  parameter int OUT_W   = DEF_OUT_W,
  parameter int PEAK    = DEF_PEAK
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rd_en,
  input  logic               clr,
  input  logic [PHASE_W-3:0] addr,
  output logic [OUT_W-1:0]   data
);

  localparam int DEPTH = 2 ** (PHASE_W - 2);

  logic [OUT_W-1:0] rom [DEPTH];
  logic [OUT_W-1:0] data_d;
  logic [OUT_W-1:0] data_q;

  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    assign rom[g] = OUT_W'(sine_rom_val(g, PHASE_W, PEAK));
  end

  always_comb begin
    data_d = data_q;
    if (rd_en) data_d = clr ? '0 : rom[addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_q <= '0;
    else        data_q <= data_d;
  end

  assign data = data_q;

endmodule

// File: rtl/sine_ref_gen.sv
// rtl/sine_ref_gen.sv - multi-channel NCO sine reference: accumulator, phase offsets, ROM, MI scaling
module sine_ref_gen
  import sspwm_pkg::*;
#(
  parameter int PHASE_W = DEF_PHASE_W,
  parameter int ACC_W   = DEF_ACC_W,
  parameter int OUT_W   = DEF_OUT_W,
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int PEAK    = DEF_PEAK,
  parameter int MI_W    = DEF_MI_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    tick,
  input  logic                    sync_clr,
  input  logic                    load,
  input  logic [ACC_W-1:0]        freq_word,
  input  logic [MI_W:0]           mi,
  input  logic                    mode,
  output logic [NUM_CH*OUT_W-1:0] sine_out,
  output logic [NUM_CH-1:0]       sign_out,
  output logic                    out_valid
);

  localparam int QW = PHASE_W - 2;
  localparam int PW = OUT_W + MI_W + 1;
  localparam logic [MI_W:0]    MI_ONE = {1'b1, {MI_W{1'b0}}};
  localparam logic [ACC_W-1:0] CH_OFF = ACC_W'(chan_offset(ACC_W, NUM_CH));

  logic [ACC_W-1:0] acc_d, acc_q, freq_act_d, freq_act_q, freq_sh_d, freq_sh_q;
  logic [MI_W:0]    mi_act_d, mi_act_q, mi_sh_d, mi_sh_q, mi1_d, mi1_q, mi2_d, mi2_q;
  logic             pending_d, pending_q;
  logic             v0_d, v0_q, v1_d, v1_q, v2_d, v2_q, out_valid_d, out_valid_q;
  logic [NUM_CH-1:0][QW-1:0]    q1_d, q1_q;
  logic [NUM_CH-1:0]            sgn1_d, sgn1_q, zero1_d, zero1_q, sgn2_d, sgn2_q;
  logic [NUM_CH-1:0][OUT_W-1:0] lut2, sine_d, sine_q;
  logic [NUM_CH-1:0]            sign_d, sign_q;

  logic [ACC_W:0]     sum;
  logic               adv, copy;
  logic [MI_W:0]      mi_clamp;
  logic [ACC_W-1:0]   ph_off;
  logic [PHASE_W-1:0] idx;

  always_comb begin
    sum      = {1'b0, acc_q} + {1'b0, freq_act_q};
    adv      = en && tick && !sync_clr;
    // A load on the copy edge wins: the fresh value waits for the next copy opportunity.
    copy     = pending_q && !load && (!en || (adv && sum[ACC_W]));
    mi_clamp = (mi > MI_ONE) ? MI_ONE : mi;

    acc_d      = sync_clr ? '0 : (adv ? sum[ACC_W-1:0] : acc_q);
    freq_act_d = copy ? freq_sh_q : freq_act_q;
    mi_act_d   = copy ? mi_sh_q : mi_act_q;
    freq_sh_d  = load ? freq_word : freq_sh_q;
    mi_sh_d    = load ? mi_clamp : mi_sh_q;
    pending_d  = load || (pending_q && !copy);

    v0_d        = adv;
    v1_d        = v0_q;
    v2_d        = v1_q;
    out_valid_d = v2_q;

    q1_d    = q1_q;
    sgn1_d  = sgn1_q;
    zero1_d = zero1_q;
    mi1_d   = v0_q ? mi_act_q : mi1_q;
    ph_off  = '0;
    idx     = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = PHASE_W'((acc_q + ph_off) >> (ACC_W - PHASE_W));
      if (v0_q) begin
        q1_d[k]    = idx[PHASE_W-2] ? ~idx[QW-1:0] : idx[QW-1:0];
        sgn1_d[k]  = (mode == MODE_RECT) && idx[PHASE_W-1];
        zero1_d[k] = (mode == MODE_HALF) && idx[PHASE_W-1];
      end
      ph_off = ph_off + CH_OFF;
    end

    sgn2_d = v1_q ? sgn1_q : sgn2_q;
    mi2_d  = v1_q ? mi1_q : mi2_q;

    sine_d = sine_q;
    sign_d = sign_q;
    if (v2_q) begin
      for (int k = 0; k < NUM_CH; k++) begin
        sine_d[k] = OUT_W'((PW'(lut2[k]) * PW'(mi2_q)) >> MI_W);
      end
      sign_d = sgn2_q;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    sine_quarter_rom #(
      .PHASE_W(PHASE_W),
      .OUT_W  (OUT_W),
      .PEAK   (PEAK)
    ) u_rom (
      .clk  (clk),
      .rst_n(rst_n),
      .rd_en(v1_q),
      .clr  (zero1_q[k]),
      .addr (q1_q[k]),
      .data (lut2[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      freq_act_q  <= '0;
      freq_sh_q   <= '0;
      mi_act_q    <= '0;
      mi_sh_q     <= '0;
      pending_q   <= 1'b0;
      v0_q        <= 1'b0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      q1_q        <= '0;
      sgn1_q      <= '0;
      zero1_q     <= '0;
      mi1_q       <= '0;
      sgn2_q      <= '0;
      mi2_q       <= '0;
      sine_q      <= '0;
      sign_q      <= '0;
    end else begin
      acc_q       <= acc_d;
      freq_act_q  <= freq_act_d;
      freq_sh_q   <= freq_sh_d;
      mi_act_q    <= mi_act_d;
      mi_sh_q     <= mi_sh_d;
      pending_q   <= pending_d;
      v0_q        <= v0_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      out_valid_q <= out_valid_d;
      q1_q        <= q1_d;
      sgn1_q      <= sgn1_d;
      zero1_q     <= zero1_d;
      mi1_q       <= mi1_d;
      sgn2_q      <= sgn2_d;
      mi2_q       <= mi2_d;
      sine_q      <= sine_d;
      sign_q      <= sign_d;
    end
  end

  assign sine_out  = sine_q;
  assign sign_out  = sign_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_sine_ref_gen.sv
// tb/tb_sine_ref_gen.sv - randomized bench for sine_ref_gen against a real-arithmetic sine model
module tb_sine_ref_gen;

  localparam int PHASE_W = 8;
  localparam int ACC_W   = 16;
  localparam int OUT_W   = 12;
  localparam int NUM_CH  = 3;
  localparam int PEAK    = 3710;
  localparam int MI_W    = 8;
  localparam int MOD     = 2 ** ACC_W;
  localparam int OFF     = MOD / NUM_CH;
  localparam int HALF    = 2 ** (PHASE_W - 1);
  localparam int UNITY   = 2 ** MI_W;
  localparam real PI     = 3.14159265358979323846;

  logic                    clk = 1'b0;
  logic                    rst_n, en, tick, sync_clr, load, mode;
  logic [ACC_W-1:0]        freq_word;
  logic [MI_W:0]           mi;
  logic [NUM_CH*OUT_W-1:0] sine_out;
  logic [NUM_CH-1:0]       sign_out;
  logic                    out_valid;

  always #5 clk = ~clk;

  sine_ref_gen #(
    .PHASE_W(PHASE_W), .ACC_W(ACC_W), .OUT_W(OUT_W),
    .NUM_CH(NUM_CH), .PEAK(PEAK), .MI_W(MI_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .tick(tick), .sync_clr(sync_clr),
    .load(load), .freq_word(freq_word), .mi(mi), .mode(mode),
    .sine_out(sine_out), .sign_out(sign_out), .out_valid(out_valid)
  );

  typedef struct {
    bit                      v;
    logic [NUM_CH*OUT_W-1:0] s;
    logic [NUM_CH-1:0]       g;
  } smp_t;

  int n_chk = 0;
  int n_pass = 0;
  bit md = 0;

  int unsigned m_acc, m_fa, m_ma, m_fs, m_ms;
  bit          m_pend;
  smp_t        hist[$];
  bit                      exp_valid;
  logic [NUM_CH*OUT_W-1:0] exp_sine;
  logic [NUM_CH-1:0]       exp_sign;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_acc = 0; m_fa = 0; m_ma = 0; m_fs = 0; m_ms = 0; m_pend = 0;
    hist.delete();
    exp_valid = 0; exp_sine = '0; exp_sign = '0;
  endtask

  function automatic smp_t ref_sample(input int unsigned a, input int unsigned m, input bit rect);
    smp_t r;
    int unsigned ph, idx, h, base, val;
    bit s;
    r.v = 1; r.s = '0; r.g = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      ph   = (a + k * OFF) % MOD;
      idx  = ph / (MOD / (2 ** PHASE_W));
      h    = idx % HALF;
      s    = idx >= HALF;
      base = $rtoi(PEAK * $sin(PI * h / (HALF - 1)) + 0.5);
      if (!rect && s) base = 0;
      val  = base * m / UNITY;
      r.s[k*OUT_W +: OUT_W] = val[OUT_W-1:0];
      r.g[k] = rect && s;
    end
    return r;
  endfunction

  task automatic model_edge();
    bit adv, carry, copy;
    int unsigned sum;
    smp_t ent, out;
    if (!rst_n) begin
      model_reset();
      return;
    end
    adv   = en && tick && !sync_clr;
    sum   = m_acc + m_fa;
    carry = adv && (sum >= MOD);
    copy  = m_pend && !load && (!en || carry);
    if (sync_clr) m_acc = 0;
    else if (adv) m_acc = sum % MOD;
    if (copy) begin m_fa = m_fs; m_ma = m_ms; end
    if (load) begin
      m_fs = freq_word;
      m_ms = (mi > UNITY) ? UNITY : mi;
      m_pend = 1;
    end else if (copy) m_pend = 0;
    ent.v = 0; ent.s = '0; ent.g = '0;
    if (adv) ent = ref_sample(m_acc, m_ma, md);
    out.v = 0; out.s = '0; out.g = '0;
    if (hist.size() == 3) out = hist.pop_front();
    hist.push_back(ent);
    exp_valid = out.v;
    if (out.v) begin exp_sine = out.s; exp_sign = out.g; end
  endtask

  task automatic step(input bit t, input bit e, input bit sc, input bit ld,
                      input logic [ACC_W-1:0] fw, input logic [MI_W:0] m);
    tick = t; en = e; sync_clr = sc; load = ld; freq_word = fw; mi = m; mode = md;
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check("out_valid", out_valid, exp_valid);
    check("sine_out", sine_out, exp_sine);
    check("sign_out", sign_out, exp_sign);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0, '0);
  endtask

  initial begin
    rst_n = 0; en = 0; tick = 0; sync_clr = 0; load = 0; mode = 0;
    freq_word = '0; mi = '0;
    model_reset();
    @(negedge clk);
    idle(2);
    check("rst_sine", sine_out, 0);
    check("rst_valid", out_valid, 0);
    rst_n = 1;
    idle(2);

    // Full-cycle amplitude sweep at unity MI, half-wave mode.
    step(0, 0, 0, 1, 16'h0100, 9'd256);
    idle(1);
    for (int i = 0; i < 270; i++) step(1, 1, 0, 0, '0, '0);
    idle(4);

    // Channel offsets in both modes.
    step(0, 0, 0, 1, 16'h0000, 9'd256);
    idle(1);
    step(0, 1, 1, 0, '0, '0);
    step(1, 1, 0, 0, '0, '0);
    idle(4);
    check("ofs_half_ch0", sine_out[11:0], 0);
    check("ofs_half_ch1", sine_out[23:12], 3198);
    check("ofs_half_ch2", sine_out[35:24], 0);
    md = 1;
    step(0, 1, 1, 0, '0, '0);
    step(1, 1, 0, 0, '0, '0);
    idle(4);
    check("ofs_rect_ch2", sine_out[35:24], 3198);
    check("ofs_rect_sign2", sign_out[2], 1);
    md = 0;

    // Scaling at idx 64, then clamp.
    step(0, 0, 0, 1, 16'h4000, 9'd128);
    idle(1);
    step(0, 1, 1, 0, '0, '0);
    step(1, 1, 0, 0, '0, '0);
    idle(4);
    check("mi_half", sine_out[11:0], 1855);
    step(0, 0, 0, 1, 16'h0000, 9'd300);
    idle(1);
    step(1, 1, 0, 0, '0, '0);
    idle(4);
    check("mi_clamp", sine_out[11:0], 3710);

    // Frequency/MI change requested mid-cycle must wait for the wrap.
    step(0, 0, 0, 1, 16'h0100, 9'd256);
    idle(1);
    step(0, 1, 1, 0, '0, '0);
    for (int i = 0; i < 420; i++)
      step(1, 1, 0, m_acc == 32'h4000, 16'h0200, 9'($urandom_range(0, 511)));

    // Load coinciding with carrying ticks is deferred.
    for (int i = 0; i < 300; i++) begin
      bit c;
      c = ((m_acc + m_fa) >= MOD) && (i < 150);
      step(1, 1, 0, c, 16'h0300, 9'($urandom_range(0, 511)));
    end

    // sync_clr with tick launches nothing.
    step(1, 1, 1, 0, '0, '0);
    idle(4);

    // Randomized run in both modes.
    for (int b = 0; b < 2; b++) begin
      md = bit'(b);
      idle(4);
      for (int i = 0; i < 1400; i++) begin
        logic [ACC_W-1:0] fw;
        fw = ($urandom_range(0, 3) == 0) ? ACC_W'($urandom) : (16'h0100 << $urandom_range(0, 6));
        step($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0, $urandom_range(0, 40) == 0,
             $urandom_range(0, 30) == 0, fw, 9'($urandom_range(0, 511)));
      end
    end
    idle(4);
    md = 0;

    // Reset with three samples in flight.
    step(0, 0, 0, 1, 16'h1234, 9'd200);
    idle(1);
    for (int i = 0; i < 6; i++) step(1, 1, 0, 0, '0, '0);
    #2;
    rst_n = 0;
    #1;
    check("arst_sine", sine_out, 0);
    check("arst_sign", sign_out, 0);
    check("arst_valid", out_valid, 0);
    model_reset();
    @(negedge clk);
    idle(2);
    rst_n = 1;
    idle(5);
    step(0, 0, 0, 1, 16'h0500, 9'd200);
    idle(1);
    step(1, 1, 0, 0, '0, '0);
    idle(5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
